// File: rtl/sad_pkg.sv
// ----------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the SAD datapath.
//   SAD_ADDR_WIDTH / SAD_DATA_WIDTH : geometry of the SAD result SRAM, also
//                                     used by the SRAM itself.
//   SAD_ST_*                        : state encoding of sad_result_scanner.
//   sad_state_e                     : typed scanner state.
// Build option: SAD_CLEAR_AFTER_SCAN_EN adds the CLEAR state.
// ----------------------------------------------------------------------------
package sad_pkg;

    localparam int SAD_ADDR_WIDTH = 7;
    localparam int SAD_DATA_WIDTH = 32;

    localparam logic [2:0] SAD_ST_IDLE  = 3'd0;
    localparam logic [2:0] SAD_ST_READ  = 3'd1;
    localparam logic [2:0] SAD_ST_DRAIN = 3'd2;
    localparam logic [2:0] SAD_ST_DONE  = 3'd3;
    localparam logic [2:0] SAD_ST_CLEAR = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = SAD_ST_IDLE,
        ST_READ  = SAD_ST_READ,
        ST_DRAIN = SAD_ST_DRAIN,
        ST_DONE  = SAD_ST_DONE
`ifdef SAD_CLEAR_AFTER_SCAN_EN
        , ST_CLEAR = SAD_ST_CLEAR
`endif
    } sad_state_e;

endpackage

// File: rtl/sad_result_scanner_if.sv
// ----------------------------------------------------------------------------
// sad_result_scanner_if
// Bundles the scanner's control handshake and its SRAM read/write port.
//   Start          : single-cycle scan request (to scanner)
//   Sram_En/RW/Addr/Data_In : SRAM command, driven by the scanner
//   Sram_Data_Out  : SRAM read data, valid the cycle after a read edge
//   Busy/Done      : scan in progress / one-cycle completion pulse
//   Min_Sad/Min_Addr : scan result
//   dbg_state      : scanner FSM state, for observation only
// Handshake: Start is a request pulse honoured only while Busy is low;
// Done is a one-cycle pulse, after which Min_Sad/Min_Addr are final and
// hold until the next accepted Start.
// Modports: master = scanner side, slave = SRAM/control side.
// ----------------------------------------------------------------------------
interface sad_result_scanner_if
    import sad_pkg::*;
#(
    parameter int ADDR_WIDTH = SAD_ADDR_WIDTH,
    parameter int DATA_WIDTH = SAD_DATA_WIDTH
);
    logic                  Start;
    logic                  Sram_En;
    logic                  Sram_RW;
    logic [ADDR_WIDTH-1:0] Sram_Addr;
    logic [DATA_WIDTH-1:0] Sram_Data_Out;
    logic [DATA_WIDTH-1:0] Sram_Data_In;
    logic                  Busy;
    logic                  Done;
    logic [DATA_WIDTH-1:0] Min_Sad;
    logic [ADDR_WIDTH-1:0] Min_Addr;
    sad_state_e            dbg_state;

    modport master (
        input  Start, Sram_Data_Out,
        output Sram_En, Sram_RW, Sram_Addr, Sram_Data_In,
               Busy, Done, Min_Sad, Min_Addr, dbg_state
    );

    modport slave (
        output Start, Sram_Data_Out,
        input  Sram_En, Sram_RW, Sram_Addr, Sram_Data_In,
               Busy, Done, Min_Sad, Min_Addr, dbg_state
    );
endinterface

// File: rtl/sad_min_tracker.sv
// ----------------------------------------------------------------------------
// sad_min_tracker
// Follows the SRAM's one-cycle read latency and keeps the running minimum.
//   Clk, Rst    : clock, asynchronous active-low reset
//   scan_start  : accepted Start; reinitialises the result
//   rd_issue    : a read is issued this cycle (sampled by the SRAM at the edge)
//   rd_addr     : address of that read
//   rd_data     : SRAM Data_Out, valid the cycle after rd_issue
//   min_sad     : smallest value seen (all ones when nothing smaller found)
//   min_addr    : address of the first occurrence of that value
// ----------------------------------------------------------------------------
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int ADDR_WIDTH = SAD_ADDR_WIDTH,
    parameter int DATA_WIDTH = SAD_DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  scan_start,
    input  logic                  rd_issue,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] min_sad,
    output logic [ADDR_WIDTH-1:0] min_addr
);
    // rd_vld/rd_adr delay the read command by one cycle so they line up
    // with the data returned by the SRAM.
    logic                  rd_vld_q,   rd_vld_d;
    logic [ADDR_WIDTH-1:0] rd_adr_q,   rd_adr_d;
    logic [DATA_WIDTH-1:0] min_sad_q,  min_sad_d;
    logic [ADDR_WIDTH-1:0] min_addr_q, min_addr_d;

    always_comb begin
        rd_vld_d   = rd_issue;
        rd_adr_d   = rd_addr;
        min_sad_d  = min_sad_q;
        min_addr_d = min_addr_q;
        if (scan_start) begin
            min_sad_d  = '1;
            min_addr_d = '0;
        end else if (rd_vld_q && (rd_data < min_sad_q)) begin
            // Strict compare: on ties the earlier (lower) address is kept.
            min_sad_d  = rd_data;
            min_addr_d = rd_adr_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_vld_q   <= 1'b0;
            rd_adr_q   <= '0;
            min_sad_q  <= '1;
            min_addr_q <= '0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            rd_adr_q   <= rd_adr_d;
            min_sad_q  <= min_sad_d;
            min_addr_q <= min_addr_d;
        end
    end

    assign min_sad  = min_sad_q;
    assign min_addr = min_addr_q;
endmodule

// File: rtl/sad_result_scanner.sv
// ----------------------------------------------------------------------------
// sad_result_scanner
// Read-side master of the SAD result SRAM. On Start it reads words
// 0..NUM_ENTRIES-1 and reports the minimum SAD and its address.
//   Clk  : clock, rising edge
//   Rst  : asynchronous reset, active low
//   bus  : sad_result_scanner_if.master (Start, SRAM port, Busy, Done,
//          Min_Sad, Min_Addr, dbg_state)
// Build option: SAD_CLEAR_AFTER_SCAN_EN -- after the reads, write zero to
// every scanned word before signalling Done.
// ----------------------------------------------------------------------------
module sad_result_scanner
    import sad_pkg::*;
#(
    parameter int ADDR_WIDTH  = SAD_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SAD_DATA_WIDTH,
    parameter int NUM_ENTRIES = 128
) (
    input  logic                 Clk,
    input  logic                 Rst,
    sad_result_scanner_if.master bus
);
    // One extra bit so NUM_ENTRIES = 2**ADDR_WIDTH (and the drain count
    // past it) never wraps.
    localparam int            CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_ENTRIES - 1);
    localparam logic [CW-1:0] DRAIN_END = CW'(NUM_ENTRIES + 1);

    sad_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          clear_phase;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Two cycles: the last word is compared at the end of the
                // first, and the second gives the final result a settled
                // cycle before the clear sweep or Done.
                if (cnt_q == DRAIN_END) begin
                    cnt_d = '0;
`ifdef SAD_CLEAR_AFTER_SCAN_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SAD_CLEAR_AFTER_SCAN_EN
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SAD_CLEAR_AFTER_SCAN_EN
    assign clear_phase = (state_q == ST_CLEAR);
`else
    assign clear_phase = 1'b0;
`endif

    // All SRAM controls come from registers; the counter is the address.
    assign bus.Sram_En      = (state_q == ST_READ) || clear_phase;
    assign bus.Sram_RW      = clear_phase;
    assign bus.Sram_Addr    = cnt_q[ADDR_WIDTH-1:0];
    assign bus.Sram_Data_In = '0;
    assign bus.Busy         = (state_q != ST_IDLE);
    assign bus.Done         = (state_q == ST_DONE);
    assign bus.dbg_state    = state_q;

    sad_min_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_min_tracker (
        .Clk        (Clk),
        .Rst        (Rst),
        .scan_start ((state_q == ST_IDLE) && bus.Start),
        .rd_issue   (state_q == ST_READ),
        .rd_addr    (cnt_q[ADDR_WIDTH-1:0]),
        .rd_data    (bus.Sram_Data_Out),
        .min_sad    (bus.Min_Sad),
        .min_addr   (bus.Min_Addr)
    );
endmodule

// File: tb/tb_sad_result_scanner.sv
// ----------------------------------------------------------------------------
// tb_sad_result_scanner
// Directed bench for sad_result_scanner: one instance with NUM_ENTRIES=4 and
// one with NUM_ENTRIES=128, each attached to a small SRAM model with a
// one-cycle read latency.
// ----------------------------------------------------------------------------
module tb_sad_result_scanner;
    import sad_pkg::*;

    localparam int AW = SAD_ADDR_WIDTH;
    localparam int DW = SAD_DATA_WIDTH;
`ifdef SAD_CLEAR_AFTER_SCAN_EN
    localparam int LAT_A = 10;
    localparam int LAT_B = 258;
`else
    localparam int LAT_A = 6;
    localparam int LAT_B = 130;
`endif

    logic          Clk = 1'b0;
    logic          Rst;
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] all1   = '1;

    always #5 Clk = ~Clk;

    sad_result_scanner_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    sad_result_scanner_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    sad_result_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(4)) dut_a (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_a.master)
    );

    sad_result_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(128)) dut_b (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_b.master)
    );

    // SRAM models: contents loaded from pre_* on a load strobe, otherwise
    // registered read / write on En.
    logic [DW-1:0] mem_a [128];
    logic [DW-1:0] mem_b [128];
    logic [DW-1:0] pre_a [128];
    logic [DW-1:0] pre_b [128];
    logic          load_a = 1'b0;
    logic          load_b = 1'b0;

    always @(posedge Clk) begin
        if (load_a) mem_a <= pre_a;
        else if (bus_a.Sram_En) begin
            if (bus_a.Sram_RW) mem_a[bus_a.Sram_Addr] <= bus_a.Sram_Data_In;
            else               bus_a.Sram_Data_Out    <= mem_a[bus_a.Sram_Addr];
        end
        if (load_b) mem_b <= pre_b;
        else if (bus_b.Sram_En) begin
            if (bus_b.Sram_RW) mem_b[bus_b.Sram_Addr] <= bus_b.Sram_Data_In;
            else               bus_b.Sram_Data_Out    <= mem_b[bus_b.Sram_Addr];
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem_a(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        for (int i = 0; i < 128; i++) pre_a[i] = '0;
        pre_a[0] = w0; pre_a[1] = w1; pre_a[2] = w2; pre_a[3] = w3;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
    endtask

    task automatic load_mem_b(input logic [DW-1:0] fill, input logic [DW-1:0] last);
        for (int i = 0; i < 127; i++) pre_b[i] = fill;
        pre_b[127] = last;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
    endtask

    // Leaves the bench 1 time unit after the edge that samples Start.
    task automatic pulse_start(input bit sel_b);
        if (sel_b) bus_b.Start = 1'b1; else bus_a.Start = 1'b1;
        tick();
        bus_a.Start = 1'b0;
        bus_b.Start = 1'b0;
    endtask

    // Counts edges after the Start-sample edge until Done is seen.
    task automatic wait_done(input bit sel_b, output int edges);
        edges = 0;
        while (((sel_b ? bus_b.Done : bus_a.Done) !== 1'b1) && (edges < 400)) begin
            tick();
            edges++;
        end
    endtask

    int edges;
    int done_cnt;

    initial begin
        bus_a.Start = 1'b0;
        bus_b.Start = 1'b0;
        Rst = 1'b1;
        #1 Rst = 1'b0;
        #2;
        // Reset state
        check("rst_busy",     bus_a.Busy,      0);
        check("rst_en",       bus_a.Sram_En,   0);
        check("rst_rw",       bus_a.Sram_RW,   0);
        check("rst_addr",     bus_a.Sram_Addr, 0);
        check("rst_done",     bus_a.Done,      0);
        check("rst_min_sad",  bus_a.Min_Sad,   all1);
        check("rst_min_addr", bus_a.Min_Addr,  0);
        check("rst_b_busy",   bus_b.Busy,      0);
        #20 Rst = 1'b1;
        tick();

        // Basic scan {40,17,99,25}: cycle-by-cycle SRAM commands
        load_mem_a(40, 17, 99, 25);
        pulse_start(0);
        for (int i = 0; i < 4; i++) begin
            check("rd_en",   bus_a.Sram_En,   1);
            check("rd_rw",   bus_a.Sram_RW,   0);
            check("rd_addr", bus_a.Sram_Addr, i);
            tick();
        end
        check("drain_en",   bus_a.Sram_En, 0);
        check("drain_busy", bus_a.Busy,    1);
        tick();
        check("drain_done", bus_a.Done,    0);
        tick();
`ifdef SAD_CLEAR_AFTER_SCAN_EN
        for (int i = 0; i < 4; i++) begin
            check("clr_en",   bus_a.Sram_En,      1);
            check("clr_rw",   bus_a.Sram_RW,      1);
            check("clr_data", bus_a.Sram_Data_In, 0);
            check("clr_addr", bus_a.Sram_Addr,    i);
            tick();
        end
`endif
        check("basic_done",     bus_a.Done,     1);
        check("basic_min_sad",  bus_a.Min_Sad,  17);
        check("basic_min_addr", bus_a.Min_Addr, 1);
        // Start during the Done cycle is ignored
        bus_a.Start = 1'b1;
        tick();
        bus_a.Start = 1'b0;
        check("start_in_done_busy", bus_a.Busy, 0);
        check("done_one_cycle",     bus_a.Done, 0);
        check("hold_min_sad",       bus_a.Min_Sad, 17);
`ifdef SAD_CLEAR_AFTER_SCAN_EN
        for (int i = 0; i < 4; i++) check("cleared_word", mem_a[i], 0);
`endif

        // Ties keep the lowest address
        load_mem_a(9, 5, 5, 7);
        pulse_start(0);
        wait_done(0, edges);
        check("tie_latency",  edges,          LAT_A);
        check("tie_min_sad",  bus_a.Min_Sad,  5);
        check("tie_min_addr", bus_a.Min_Addr, 1);
        tick();

        // Start re-pulsed mid-scan: ignored, single Done
        load_mem_a(40, 17, 99, 25);
        pulse_start(0);
        tick();
        bus_a.Start = 1'b1;
        tick();
        bus_a.Start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus_a.Done === 1'b1) done_cnt++;
            tick();
        end
        check("repulse_done_cnt", done_cnt,       1);
        check("repulse_min_sad",  bus_a.Min_Sad,  17);
        check("repulse_min_addr", bus_a.Min_Addr, 1);

        // Fresh scan after Done: result reset on the accepted Start
        load_mem_a(50, 60, 44, 80);
        pulse_start(0);
        check("fresh_min_reset", bus_a.Min_Sad, all1);
        wait_done(0, edges);
        check("fresh_latency",  edges,          LAT_A);
        check("fresh_min_sad",  bus_a.Min_Sad,  44);
        check("fresh_min_addr", bus_a.Min_Addr, 2);
        tick();

        // Reset during a scan: immediate, asynchronous, no Done
        load_mem_a(3, 1, 2, 4);
        pulse_start(0);
        tick();
        tick();
        #2 Rst = 1'b0;
        #1;
        check("midrst_busy",     bus_a.Busy,     0);
        check("midrst_en",       bus_a.Sram_En,  0);
        check("midrst_min_sad",  bus_a.Min_Sad,  all1);
        check("midrst_min_addr", bus_a.Min_Addr, 0);
        #2 Rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_a.Done === 1'b1) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        load_mem_a(3, 1, 2, 4);
        pulse_start(0);
        wait_done(0, edges);
        check("post_rst_latency",  edges,          LAT_A);
        check("post_rst_min_sad",  bus_a.Min_Sad,  1);
        check("post_rst_min_addr", bus_a.Min_Addr, 1);
        tick();

        // NUM_ENTRIES=128: all ones, then word 127 = 0
        load_mem_b(all1, all1);
        pulse_start(1);
        wait_done(1, edges);
        check("ones_latency",  edges,          LAT_B);
        check("ones_min_sad",  bus_b.Min_Sad,  all1);
        check("ones_min_addr", bus_b.Min_Addr, 0);
        tick();

        load_mem_b(32'h0000_1000, 32'h0);
        pulse_start(1);
        wait_done(1, edges);
        check("last_latency",  edges,          LAT_B);
        check("last_min_sad",  bus_b.Min_Sad,  0);
        check("last_min_addr", bus_b.Min_Addr, 127);
        tick();
        check("last_idle", bus_b.Busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
